// File: rtl/gp_adder_pkg.sv
`default_nettype none
// =============================================================================
// gp_adder_pkg : shared width, resolver state type and carry-step helper
// Rev 1.0
// =============================================================================
package gp_adder_pkg;

    localparam int ADDER_WIDTH = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } resolve_state_t;

    function automatic logic carry_step(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gp_carry_cell.sv
`default_nettype none
// =============================================================================
// gp_carry_cell : combinational single-bit sum/carry step
// Rev 1.0
// =============================================================================
module gp_carry_cell
    import gp_adder_pkg::*;
(
    input  logic g,
    input  logic h,
    input  logic p,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = h ^ c_in;
    assign c_out = carry_step(g, p, c_in);

endmodule
`default_nettype wire

// File: rtl/gp_sum_resolver.sv
`default_nettype none
// =============================================================================
// gp_sum_resolver : bit-serial carry resolver over g/h/p vectors, valid/ready I/O
// Optional signed-overflow output enabled by GP_SUM_RESOLVER_OVF_EN.  Rev 1.0
// =============================================================================
module gp_sum_resolver
    import gp_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef GP_SUM_RESOLVER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);

    resolve_state_t   r_state;
    resolve_state_t   w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_c_out;

    gp_carry_cell u_cell (
        .g     (r_g[r_idx]),
        .h     (r_h[r_idx]),
        .p     (r_p[r_idx]),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // in_ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == C_LAST_IDX) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_g     <= '0;
            r_h     <= '0;
            r_p     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_g     <= g;
            r_h     <= h;
            r_p     <= p;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[r_idx] <= w_s;
            r_carry      <= w_c_out;
            // idx parks on the last bit rather than wrapping.
            if (r_idx == C_LAST_IDX) begin
                r_cout <= w_c_out;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef GP_SUM_RESOLVER_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && r_idx == C_LAST_IDX) begin
            r_ovf <= r_carry ^ w_c_out;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_gp_sum_resolver.sv
`default_nettype none
// =============================================================================
// tb_gp_sum_resolver : directed and random checks against an arithmetic model
// Rev 1.0
// =============================================================================
module tb_gp_sum_resolver;

    localparam int W = 6;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin       = 1'b0;
    logic [W-1:0] g         = '0;
    logic [W-1:0] h         = '0;
    logic [W-1:0] p         = '0;
    logic [W-1:0] sum;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
`ifdef GP_SUM_RESOLVER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    always #5 clk = ~clk;

    gp_sum_resolver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .h         (h),
        .p         (p),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef GP_SUM_RESOLVER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer addition: unsigned for sum/cout, signed range test for overflow.
    task automatic model(input int x, input int y, input int ci);
        int total;
        int sx;
        int sy;
        int ssum;
        total    = x + y + ci;
        exp_sum  = total[W-1:0];
        exp_cout = total[W];
        sx       = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy       = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        ssum     = sx + sy + ci;
        exp_ovf  = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
    endtask

    // Presents operands at a negedge, waits for acceptance; returns at the negedge after the accept edge.
    task automatic accept(input int x, input int y, input int ci, input string tag);
        int n;
        model(x, y, ci);
        g        = W'(x & y);
        h        = W'(x ^ y);
        p        = W'(x | y);
        cin      = ci[0];
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic complete(input string tag, input int stall, input bit bp);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef GP_SUM_RESOLVER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
        for (int i = 0; i < stall; i++) begin
            if (bp) begin
                g        = W'($urandom);
                h        = W'($urandom);
                p        = W'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'b1;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum), 32'(exp_sum));
            check({tag, "_hold_cout"}, 32'(cout), 32'(exp_cout));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int x;
        int y;
        int ci;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        accept(22, 11, 0, "add22_11");
        complete("add22_11", 0, 1'b0);
        accept(63, 1, 0, "add63_1");
        complete("add63_1", 0, 1'b0);
        accept(31, 1, 0, "add31_1");
        complete("add31_1", 0, 1'b0);

        accept(5, 9, 0, "bp_first");
        complete("bp_first", 5, 1'b1);
        accept(40, 30, 1, "bp_second");
        complete("bp_second", 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            x  = int'($urandom_range(0, (1 << W) - 1));
            y  = int'($urandom_range(0, (1 << W) - 1));
            ci = int'($urandom_range(0, 1));
            accept(x, y, ci, "rand");
            complete("rand", int'($urandom_range(0, 3)), 1'($urandom));
        end

        accept(63, 0, 1, "cin_chain");
        complete("cin_chain", 0, 1'b0);

        // Abort in the third RUN cycle; cout is still 1 from the previous result.
        accept(45, 27, 0, "abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);

        accept(17, 46, 1, "post_reset");
        complete("post_reset", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
